game_ctl: RTL and testbench
===========================

# game_ctl

Parametrised game-flow controller for the VGA mouse game. It sits between cursor_sync/click_ctl-style inputs and the drawing chain. It replaces the single-button IDLE/WAIT/GAME/SCORE logic with one block that:
- hit-tests N on-screen buttons;
- runs the IDLE→WAIT→GAME→SCORE state machine;
- counts game time from frame ticks;
- keeps a saturating score.

Its outputs tell the draw_rect_char instances which buttons to show.

## Interface

Parameters:
- N_BTN, 3: number of clickable rectangles (≥3).
- PLAY_BTN, 0: button index that starts a game (IDLE).
- STOP_BTN, 1: button index that aborts (WAIT, GAME).
- TARGET_BTN, 2: button index scored during GAME.
- IDLE_MASK / WAIT_MASK / GAME_MASK / SCORE_MASK, N_BTN bits: buttons visible and clickable per state.
- FRAMES_PER_SEC, 60: vsync edges per second.
- GAME_SEC, 30: game duration in seconds (1..255).
- SCORE_HOLD_SEC, 5: seconds SCORE is shown before auto-return to IDLE.
- SCORE_W, 8: score width.

Ports (direction, width, meaning). Clock and reset first:
- pclk, in, 1: pixel clock, 40 MHz.
- rst, in, 1: reset, asynchronous, active-low.
- mouse_xpos, in, 12: cursor x, synchronous to pclk.
- mouse_ypos, in, 12: cursor y.
- mouse_left, in, 1: left button level.
- vsync_in, in, 1: frame sync from vga_timing.
- uart_start, in, 1: start request from the link (level).
- btn_hstart, in, N_BTN*11: packed x start; button i is in bits [11i+10:11i].
- btn_vstart, in, N_BTN*11: packed y start.
- btn_hlength, in, N_BTN*11: packed width.
- btn_vlength, in, N_BTN*11: packed height.
- state, out, 2: 0 IDLE, 1 WAIT, 2 GAME, 3 SCORE.
- btn_visible, out, N_BTN: mask for the current state.
- btn_clicked, out, N_BTN: one-cycle one-hot click pulse.
- time_left, out, 8: seconds remaining.
- score, out, SCORE_W: current or last score.

## Operation

- **Click edge:** left_q registers mouse_left. An edge is `mouse_left & ~left_q`.
- **Hit test for button i:** `hstart ≤ x < hstart+hlength` and `vstart ≤ y < vstart+vlength`.
  - Compare in 13 bits so the sums do not overflow.
  - A zero-length button never hits.
- **Click qualification:** only buttons in btn_visible qualify. If several qualify, the lowest index wins.
  - btn_clicked is a registered one-hot pulse, otherwise 0.
- **Frame tick:** rising edge of vsync_in, detected with a registered copy.
- **Second tick:** frame_cnt counts 0..FRAMES_PER_SEC-1. It pulses sec_tick on wrap.
  - frame_cnt clears on every state change.
- **IDLE**
  - btn_clicked[PLAY_BTN] → WAIT.
- **WAIT**
  - btn_clicked[STOP_BTN] → IDLE.
  - Otherwise uart_start=1 → GAME: load time_left=GAME_SEC and clear score.
- **GAME**
  - btn_clicked[STOP_BTN] → IDLE.
  - Otherwise, sec_tick with time_left==1 → time_left=0 and go to SCORE.
  - Otherwise sec_tick → time_left−1.
  - btn_clicked[TARGET_BTN] increments score, saturating at 2^SCORE_W−1.
- **SCORE**
  - On entry, load time_left=SCORE_HOLD_SEC.
  - sec_tick decrements time_left. Reaching 0 → IDLE.
  - btn_clicked[PLAY_BTN] → IDLE immediately.
- **Simultaneous events**
  - In GAME, STOP beats timer expiry. The target click in that cycle still counts only if STOP did not fire, which it cannot, because the pulse is one-hot.
  - In WAIT, STOP beats uart_start.
- **score** holds through SCORE and IDLE until the next GAME entry.
- **time_left**
  - Entering IDLE or WAIT sets time_left=0.
  - It never underflows.
- **btn_visible** is a registered function of the next state: it equals the mask of the new state in the same cycle the state output changes.
- **Reset (rst=0):** asynchronously sets all outputs and internal registers to 0 and state=IDLE. btn_visible is 0 during reset and IDLE_MASK from the first clock after release.
  - Reset mid-game abandons the game. The score is lost.

## Timing

- Cycle t: mouse_left samples 1 with left_q=0 and the hit is valid. → btn_clicked asserts at t+1 for exactly one cycle.
- State and btn_visible update at t+2. Score updates at t+2.
- Holding mouse_left high gives no further pulses until it is released and pressed again.
- vsync rising edge at cycle t → frame tick at t+1.
  - The sec_tick effect on time_left or state is visible at t+2.
- uart_start sampled high in WAIT at cycle t → state=GAME and time_left=GAME_SEC at t+1.
- Clicks in the cycle right after a state change are qualified against the new mask.
- All outputs are registered. No combinational path runs from input to output.

## Test plan

- **Reset:** assert rst=0 mid-frame → state=0, btn_visible=0, btn_clicked=0, time_left=0, score=0.
  - After release: btn_visible=IDLE_MASK (3'b001 with default masks set so).
- **Hit boundaries:** PLAY at hstart=380, vstart=186, 300×100.
  - Clicks at (380,186) and (679,285) → btn_clicked=001 at t+1, state=WAIT at t+2.
  - Clicks at (680,200) and (379,200) → no pulse, state stays IDLE.
- **Overlap and visibility:** buttons 0 and 2 overlap, both visible.
  - Click in the overlap → btn_clicked=001 only.
  - Click on invisible button 1 → no pulse.
- **Full game:** FRAMES_PER_SEC=2, GAME_SEC=3; 5 target clicks in GAME.
  - After 6 vsync edges → SCORE, time_left=SCORE_HOLD_SEC, score=5.
  - After SCORE_HOLD_SEC×2 more edges → IDLE, score still 5.
- **Simultaneous events:**
  - STOP click coinciding with the final sec_tick → IDLE, not SCORE.
  - In WAIT, uart_start=1 together with a STOP pulse → IDLE.
- **Saturation and mid-game reset:** SCORE_W=2, 6 target clicks → score=3.
  - rst=0 during GAME → IDLE, score=0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/game_ctl.sv
// -----------------------------------------------------------------------------
// game_ctl
//
// Game-flow controller for the VGA mouse game. It hit-tests N_BTN on-screen
// rectangles against the cursor and runs the IDLE -> WAIT -> GAME -> SCORE
// state machine. It derives second ticks from vsync and keeps a saturating
// score. Its outputs tell the drawing chain which buttons to show.
//
// Ports
//   pclk         in   1          pixel clock
//   rst          in   1          asynchronous, active-low reset
//   mouse_xpos   in   12         cursor x (pclk domain)
//   mouse_ypos   in   12         cursor y (pclk domain)
//   mouse_left   in   1          left mouse button level
//   vsync_in     in   1          frame sync; each rising edge is one frame
//   uart_start   in   1          start request level from the serial link
//   btn_hstart   in   N_BTN*11   packed x start, button i in [11i+10:11i]
//   btn_vstart   in   N_BTN*11   packed y start
//   btn_hlength  in   N_BTN*11   packed width
//   btn_vlength  in   N_BTN*11   packed height
//   state        out  2          0 IDLE, 1 WAIT, 2 GAME, 3 SCORE
//   btn_visible  out  N_BTN      visibility mask of the current state
//   btn_clicked  out  N_BTN      one-cycle one-hot click pulse
//   time_left    out  8          seconds remaining in GAME / SCORE
//   score        out  SCORE_W    current or last score
//
// Input contract: there is no handshake. uart_start is a plain level that is
// only acted on while in WAIT. A click is a 0->1 transition of mouse_left,
// taken at the cursor position of that same cycle. Every output is a flop.
// -----------------------------------------------------------------------------
module game_ctl #(
    parameter int              N_BTN          = 3,
    parameter int              PLAY_BTN       = 0,
    parameter int              STOP_BTN       = 1,
    parameter int              TARGET_BTN     = 2,
    parameter logic [N_BTN-1:0] IDLE_MASK     = N_BTN'(3'b001),
    parameter logic [N_BTN-1:0] WAIT_MASK     = N_BTN'(3'b010),
    parameter logic [N_BTN-1:0] GAME_MASK     = N_BTN'(3'b110),
    parameter logic [N_BTN-1:0] SCORE_MASK    = N_BTN'(3'b001),
    parameter int              FRAMES_PER_SEC = 60,
    parameter int              GAME_SEC       = 30,
    parameter int              SCORE_HOLD_SEC = 5,
    parameter int              SCORE_W        = 8
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic [11:0]          mouse_xpos,
    input  logic [11:0]          mouse_ypos,
    input  logic                 mouse_left,
    input  logic                 vsync_in,
    input  logic                 uart_start,
    input  logic [N_BTN*11-1:0]  btn_hstart,
    input  logic [N_BTN*11-1:0]  btn_vstart,
    input  logic [N_BTN*11-1:0]  btn_hlength,
    input  logic [N_BTN*11-1:0]  btn_vlength,
    output logic [1:0]           state,
    output logic [N_BTN-1:0]     btn_visible,
    output logic [N_BTN-1:0]     btn_clicked,
    output logic [7:0]           time_left,
    output logic [SCORE_W-1:0]   score
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_GAME  = 2'd2,
        S_SCORE = 2'd3
    } state_t;

    // A counter for FRAMES_PER_SEC == 1 still needs one bit.
    localparam int FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

    state_t               state_q, state_d;
    logic                 left_q;
    logic                 vsync_q;
    logic                 frame_tick;
    logic [FC_W-1:0]      frame_cnt;
    logic                 sec_tick;
    logic [N_BTN-1:0]     hit;
    logic [N_BTN-1:0]     qual;
    logic [N_BTN-1:0]     pick;
    logic [N_BTN-1:0]     click_q;
    logic [N_BTN-1:0]     vis_q, vis_d;
    logic [7:0]           time_q, time_d;
    logic [SCORE_W-1:0]   score_q, score_d;

    // ---------------------------------------------------------------------
    // Hit test. All operands are widened to 13 bits so start+length cannot
    // wrap. A zero length gives an empty span.
    // ---------------------------------------------------------------------
    function automatic logic in_span(input logic [12:0] pos,
                                     input logic [12:0] start,
                                     input logic [12:0] len);
        return (len != 13'd0) && (pos >= start) && (pos < start + len);
    endfunction

    for (genvar i = 0; i < N_BTN; i++) begin : g_hit
        assign hit[i] =
            in_span({1'b0, mouse_xpos}, {2'b00, btn_hstart[11*i +: 11]},
                    {2'b00, btn_hlength[11*i +: 11]}) &&
            in_span({1'b0, mouse_ypos}, {2'b00, btn_vstart[11*i +: 11]},
                    {2'b00, btn_vlength[11*i +: 11]});
    end

    // Only visible buttons qualify. x & (~x + 1) keeps the lowest set bit,
    // so overlapping buttons resolve to the lowest index.
    assign qual = hit & vis_q;
    assign pick = qual & (~qual + N_BTN'(1));

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            left_q  <= 1'b0;
            click_q <= '0;
        end else begin
            left_q  <= mouse_left;
            click_q <= (mouse_left && !left_q) ? pick : '0;
        end
    end

    // ---------------------------------------------------------------------
    // Frame and second ticks. frame_cnt restarts on every state change, so
    // each state gets whole seconds measured from its own entry.
    // ---------------------------------------------------------------------
    assign sec_tick = frame_tick && (frame_cnt == FC_W'(FRAMES_PER_SEC - 1));

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            vsync_q    <= 1'b0;
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            vsync_q    <= vsync_in;
            frame_tick <= vsync_in && !vsync_q;
            if (state_d != state_q) begin
                frame_cnt <= '0;
            end else if (frame_tick) begin
                frame_cnt <= sec_tick ? '0 : frame_cnt + FC_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // State machine, timer and score.
    // ---------------------------------------------------------------------
    function automatic logic [N_BTN-1:0] mask_of(input state_t s);
        case (s)
            S_IDLE:  return IDLE_MASK;
            S_WAIT:  return WAIT_MASK;
            S_GAME:  return GAME_MASK;
            default: return SCORE_MASK;
        endcase
    endfunction

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            time_q  <= 8'd0;
            score_q <= '0;
            vis_q   <= '0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            score_q <= score_d;
            vis_q   <= vis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        score_d = score_q;
        case (state_q)
            S_IDLE: begin
                time_d = 8'd0;
                if (click_q[PLAY_BTN]) state_d = S_WAIT;
            end
            S_WAIT: begin
                time_d = 8'd0;
                // STOP wins over a start request arriving in the same cycle.
                if (click_q[STOP_BTN]) begin
                    state_d = S_IDLE;
                end else if (uart_start) begin
                    state_d = S_GAME;
                    time_d  = 8'(GAME_SEC);
                    score_d = '0;
                end
            end
            S_GAME: begin
                // STOP wins over timer expiry in the same cycle.
                if (click_q[STOP_BTN]) begin
                    state_d = S_IDLE;
                    time_d  = 8'd0;
                end else if (sec_tick) begin
                    if (time_q <= 8'd1) begin
                        state_d = S_SCORE;
                        time_d  = 8'(SCORE_HOLD_SEC);
                    end else begin
                        time_d = time_q - 8'd1;
                    end
                end
                if (click_q[TARGET_BTN] && !click_q[STOP_BTN] &&
                    (score_q != {SCORE_W{1'b1}})) begin
                    score_d = score_q + SCORE_W'(1);
                end
            end
            S_SCORE: begin
                if (click_q[PLAY_BTN]) begin
                    state_d = S_IDLE;
                    time_d  = 8'd0;
                end else if (sec_tick) begin
                    if (time_q <= 8'd1) begin
                        state_d = S_IDLE;
                        time_d  = 8'd0;
                    end else begin
                        time_d = time_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                time_d  = 8'd0;
            end
        endcase
        // Registered with the state so the mask changes in the same cycle.
        vis_d = mask_of(state_d);
    end

    assign state       = state_q;
    assign btn_visible = vis_q;
    assign btn_clicked = click_q;
    assign time_left   = time_q;
    assign score       = score_q;

endmodule

// File: tb/tb_game_ctl.sv
// -----------------------------------------------------------------------------
// tb_game_ctl
//
// Bench for game_ctl. Two instances share all stimulus: one has an 8-bit score
// and one has a 2-bit score, which exercises saturation. The reference model
// tracks the game at the level of whole events: clicks resolve against the
// rectangle geometry, a frame count since state entry gives time_left by
// division, and the score is an unbounded count that is clamped per instance.
// -----------------------------------------------------------------------------
module tb_game_ctl;

    localparam int N_BTN = 3;
    localparam int FPS   = 2;
    localparam int GSEC  = 3;
    localparam int HOLD  = 2;
    localparam logic [2:0] M_IDLE  = 3'b001;
    localparam logic [2:0] M_WAIT  = 3'b010;
    localparam logic [2:0] M_GAME  = 3'b110;
    localparam logic [2:0] M_SCORE = 3'b101;
    localparam int PLAY = 0, STOP = 1, TARGET = 2;

    // ---------------- clock / reset / DUT ----------------
    logic        pclk, rst, mouse_left, vsync_in, uart_start;
    logic [11:0] mouse_xpos, mouse_ypos;
    logic [32:0] btn_hstart, btn_vstart, btn_hlength, btn_vlength;
    logic [1:0]  state, s_state;
    logic [2:0]  btn_visible, s_visible, btn_clicked, s_clicked;
    logic [7:0]  time_left, s_time;
    logic [7:0]  score;
    logic [1:0]  s_score;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    game_ctl #(
        .N_BTN(N_BTN), .PLAY_BTN(PLAY), .STOP_BTN(STOP), .TARGET_BTN(TARGET),
        .IDLE_MASK(M_IDLE), .WAIT_MASK(M_WAIT), .GAME_MASK(M_GAME), .SCORE_MASK(M_SCORE),
        .FRAMES_PER_SEC(FPS), .GAME_SEC(GSEC), .SCORE_HOLD_SEC(HOLD), .SCORE_W(8)
    ) dut (
        .pclk(pclk), .rst(rst), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .mouse_left(mouse_left), .vsync_in(vsync_in), .uart_start(uart_start),
        .btn_hstart(btn_hstart), .btn_vstart(btn_vstart),
        .btn_hlength(btn_hlength), .btn_vlength(btn_vlength),
        .state(state), .btn_visible(btn_visible), .btn_clicked(btn_clicked),
        .time_left(time_left), .score(score)
    );

    game_ctl #(
        .N_BTN(N_BTN), .PLAY_BTN(PLAY), .STOP_BTN(STOP), .TARGET_BTN(TARGET),
        .IDLE_MASK(M_IDLE), .WAIT_MASK(M_WAIT), .GAME_MASK(M_GAME), .SCORE_MASK(M_SCORE),
        .FRAMES_PER_SEC(FPS), .GAME_SEC(GSEC), .SCORE_HOLD_SEC(HOLD), .SCORE_W(2)
    ) dut_sat (
        .pclk(pclk), .rst(rst), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .mouse_left(mouse_left), .vsync_in(vsync_in), .uart_start(uart_start),
        .btn_hstart(btn_hstart), .btn_vstart(btn_vstart),
        .btn_hlength(btn_hlength), .btn_vlength(btn_vlength),
        .state(s_state), .btn_visible(s_visible), .btn_clicked(s_clicked),
        .time_left(s_time), .score(s_score)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, observed no summary, required summary");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int bx[3] = '{380, 20, 600};
    int by[3] = '{186, 20, 250};
    int bw[3] = '{300, 100, 150};
    int bh[3] = '{100, 50, 100};

    int m_state, m_frames, m_score;
    int tests_run, tests_failed;

    function automatic int mask_of(input int s);
        case (s)
            0:       return int'(M_IDLE);
            1:       return int'(M_WAIT);
            2:       return int'(M_GAME);
            default: return int'(M_SCORE);
        endcase
    endfunction

    function automatic int model_time();
        if (m_state == 2) return GSEC - m_frames / FPS;
        if (m_state == 3) return HOLD - m_frames / FPS;
        return 0;
    endfunction

    function automatic int clamp(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int model_pick(input int x, input int y);
        int m;
        m = mask_of(m_state);
        for (int i = 0; i < 3; i++) begin
            if (((m >> i) & 1) == 1 && x >= bx[i] && x < bx[i] + bw[i] &&
                y >= by[i] && y < by[i] + bh[i]) return i;
        end
        return -1;
    endfunction

    task automatic go(input int s);
        if (s != m_state) begin
            m_state  = s;
            m_frames = 0;
        end
    endtask

    task automatic model_click(input int b);
        case (m_state)
            0: if (b == PLAY) go(1);
            1: if (b == STOP) go(0);
            2: if (b == STOP) go(0); else if (b == TARGET) m_score++;
            3: if (b == PLAY) go(0);
            default: ;
        endcase
    endtask

    task automatic model_frame();
        m_frames++;
        if (m_state == 2 && m_frames == GSEC * FPS) go(3);
        else if (m_state == 3 && m_frames == HOLD * FPS) go(0);
    endtask

    task automatic model_uart();
        if (m_state == 1) begin
            go(2);
            m_score = 0;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_state"},     32'(state),       32'(m_state));
        check({tag, "_visible"},   32'(btn_visible), 32'(mask_of(m_state)));
        check({tag, "_time"},      32'(time_left),   32'(model_time()));
        check({tag, "_score"},     32'(score),       32'(clamp(m_score, 255)));
        check({tag, "_sat_state"}, 32'(s_state),     32'(m_state));
        check({tag, "_sat_score"}, 32'(s_score),     32'(clamp(m_score, 3)));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic rand_point(input int kind, output int x, output int y);
        if (kind == 0) begin
            x = int'($urandom_range(0, 1023));
            y = int'($urandom_range(0, 767));
        end else begin
            x = bx[kind-1] + int'($urandom_range(0, bw[kind-1] - 1));
            y = by[kind-1] + int'($urandom_range(0, bh[kind-1] - 1));
        end
    endtask

    task automatic check_pulse(input string tag, input int b);
        int exp;
        exp = (b < 0) ? 0 : (1 << b);
        check({tag, "_pulse"},     32'(btn_clicked), 32'(exp));
        check({tag, "_sat_pulse"}, 32'(s_clicked),   32'(exp));
    endtask

    task automatic do_click(input int x, input int y, input string tag);
        int b;
        b = model_pick(x, y);
        mouse_xpos = 12'(x); mouse_ypos = 12'(y); mouse_left = 1'b1;
        tick();
        check_pulse(tag, b);
        mouse_left = 1'b0;
        model_click(b);
        tick();
        check({tag, "_pulse_end"}, 32'(btn_clicked), 32'd0);
        check_all(tag);
    endtask

    task automatic do_click_vsync(input int x, input int y, input string tag);
        int b;
        b = model_pick(x, y);
        mouse_xpos = 12'(x); mouse_ypos = 12'(y); mouse_left = 1'b1; vsync_in = 1'b1;
        tick();
        check_pulse(tag, b);
        mouse_left = 1'b0; vsync_in = 1'b0;
        model_click(b);
        model_frame();
        tick();
        check_all(tag);
    endtask

    task automatic do_click_uart(input int x, input int y, input string tag);
        int b, s0;
        b = model_pick(x, y);
        mouse_xpos = 12'(x); mouse_ypos = 12'(y); mouse_left = 1'b1;
        tick();
        check_pulse(tag, b);
        mouse_left = 1'b0; uart_start = 1'b1;
        s0 = m_state;
        model_click(b);
        if (s0 == 1 && m_state == 1) model_uart();
        tick();
        uart_start = 1'b0;
        check_all(tag);
    endtask

    task automatic do_vsync(input string tag);
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        model_frame();
        tick();
        check_all(tag);
    endtask

    task automatic do_uart(input string tag);
        uart_start = 1'b1;
        tick();
        uart_start = 1'b0;
        model_uart();
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        #3 rst = 1'b0;
        #1;
        m_state = 0; m_frames = 0; m_score = 0;
        check({tag, "_state"},   32'(state),       32'd0);
        check({tag, "_visible"}, 32'(btn_visible), 32'd0);
        check({tag, "_clicked"}, 32'(btn_clicked), 32'd0);
        check({tag, "_time"},    32'(time_left),   32'd0);
        check({tag, "_score"},   32'(score),       32'd0);
        check({tag, "_sat"},     32'(s_score),     32'd0);
        #1 rst = 1'b1;
        check({tag, "_vis_released"}, 32'(btn_visible), 32'd0);
        tick();
        check({tag, "_vis_first_clk"}, 32'(btn_visible), 32'(M_IDLE));
        check_all(tag);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int x, y, cl, vs, op;
        tests_run = 0; tests_failed = 0;
        m_state = 0; m_frames = 0; m_score = 0;
        rst = 1'b1; mouse_left = 1'b0; vsync_in = 1'b0; uart_start = 1'b0;
        mouse_xpos = 12'd0; mouse_ypos = 12'd0;
        btn_hstart  = {11'd600, 11'd20,  11'd380};
        btn_vstart  = {11'd250, 11'd20,  11'd186};
        btn_hlength = {11'd150, 11'd100, 11'd300};
        btn_vlength = {11'd100, 11'd50,  11'd100};
        tick(); tick();
        do_reset("reset");

        // Hit boundaries and an invisible button while IDLE.
        do_click(680, 200, "miss_right");
        do_click(379, 200, "miss_left");
        do_click(380, 286, "miss_below");
        do_click(50, 40, "invisible_stop");
        check("idle_kept", 32'(state), 32'd0);
        do_click(380, 186, "hit_corner_lo");
        check("corner_lo_wait", 32'(state), 32'd1);
        do_click(50, 40, "stop_in_wait");
        do_click(679, 285, "hit_corner_hi");
        check("corner_hi_wait", 32'(state), 32'd1);
        do_click(50, 40, "stop_again");

        // Holding the button produces a single pulse.
        mouse_xpos = 12'd400; mouse_ypos = 12'd200; mouse_left = 1'b1;
        tick();
        check("hold_first_pulse", 32'(btn_clicked), 32'd1);
        model_click(PLAY);
        tick();
        check_all("hold_wait");
        mouse_xpos = 12'd50; mouse_ypos = 12'd40;
        repeat (3) begin
            tick();
            check("hold_no_pulse", 32'(btn_clicked), 32'd0);
        end
        check_all("hold_still_wait");
        mouse_left = 1'b0;
        tick();

        // STOP beats uart_start in WAIT.
        do_click_uart(60, 30, "stop_vs_uart");
        check("stop_vs_uart_idle", 32'(state), 32'd0);

        // Full game: 5 target clicks interleaved with frames, then 6th frame.
        do_click(400, 200, "g1_play");
        do_uart("g1_start");
        check("g1_time_loaded", 32'(time_left), 32'(GSEC));
        cl = 5; vs = 5;
        while (cl > 0 || vs > 0) begin
            if (cl > 0 && (vs == 0 || $urandom_range(0, 1) == 1)) begin
                rand_point(3, x, y);
                do_click(x, y, "g1_target");
                cl--;
            end else begin
                do_vsync("g1_frame");
                vs--;
            end
        end
        do_vsync("g1_end");
        check("g1_end_state", 32'(state), 32'd3);
        check("g1_end_time", 32'(time_left), 32'(HOLD));
        check("g1_end_score", 32'(score), 32'd5);
        check("g1_end_sat", 32'(s_score), 32'd3);
        repeat (2 * HOLD) do_vsync("g1_hold");
        check("g1_back_idle", 32'(state), 32'd0);
        check("g1_score_kept", 32'(score), 32'd5);

        // STOP together with the final second tick.
        do_click(400, 200, "g2_play");
        do_uart("g2_start");
        repeat (5) do_vsync("g2_frame");
        rand_point(2, x, y);
        do_click_vsync(x, y, "g2_stop_vs_expiry");
        check("g2_idle_not_score", 32'(state), 32'd0);

        // SCORE state: overlapping buttons 0 and 2 both visible.
        do_click(400, 200, "g3_play");
        do_uart("g3_start");
        repeat (6) do_vsync("g3_frame");
        check("g3_in_score", 32'(state), 32'd3);
        do_click(650, 260, "g3_overlap");
        check("g3_overlap_idle", 32'(state), 32'd0);

        // Reset in the middle of a game drops the score at once.
        do_click(400, 200, "g4_play");
        do_uart("g4_start");
        do_click(720, 300, "g4_target");
        do_click(700, 330, "g4_target");
        do_reset("midgame_reset");

        // Random operations checked against the model.
        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1: begin rand_point(0, x, y); do_click(x, y, "r_any"); end
                2:    begin rand_point(1, x, y); do_click(x, y, "r_play"); end
                3:    begin
                          rand_point(($urandom_range(0, 3) == 0) ? 2 : 3, x, y);
                          do_click(x, y, "r_stop_tgt");
                      end
                4, 5: begin rand_point(3, x, y); do_click(x, y, "r_target"); end
                6, 7: do_vsync("r_frame");
                8:    do_uart("r_uart");
                default: begin
                    case ($urandom_range(0, 2))
                        0: begin rand_point(int'($urandom_range(1, 3)), x, y);
                                 do_click_vsync(x, y, "r_click_frame"); end
                        1: begin rand_point(int'($urandom_range(1, 2)), x, y);
                                 do_click_uart(x, y, "r_click_uart"); end
                        default: begin
                            tick();
                            check("r_idle_pulse", 32'(btn_clicked), 32'd0);
                            check_all("r_idle");
                        end
                    endcase
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
